// File: rtl/rr_mux_arbiter_pkg.sv
// Shared types and defaults for the round-robin mux arbiter.
package mux_arb_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_t;

  localparam int DEFAULT_DATA_W = 8;
  localparam int DEFAULT_N_REQ  = 4;

endpackage

// File: rtl/rr_mux_arbiter_pick.sv
// Round-robin winner search: first set request at or after ptr, wrapping.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int PTR_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [PTR_W-1:0] winner_o,
  output logic             any_req_o
);

  localparam int IDX_W = PTR_W + 1;

  logic [2*N_REQ-1:0] dbl;
  logic [2*N_REQ-1:0] masked;
  logic [IDX_W-1:0]   idx;

  // The upper copy is never masked, so wrapped requests are still found.
  always_comb begin
    dbl       = {req_i, req_i};
    masked    = '0;
    idx       = '0;
    any_req_o = |req_i;
    for (int j = 0; j < 2*N_REQ; j++) begin
      masked[j] = dbl[j] && (j >= int'(ptr_i));
    end
    for (int j = 2*N_REQ-1; j >= 0; j--) begin
      if (masked[j]) idx = IDX_W'(j);
    end
    if (idx >= IDX_W'(N_REQ)) winner_o = PTR_W'(idx - IDX_W'(N_REQ));
    else                      winner_o = PTR_W'(idx);
  end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter feeding N_REQ producers into one registered output slot
// through a 2:1 mux tree on the granted requester's payload.
module rr_mux_arbiter
  import mux_arb_pkg::*;
#(
  parameter int N_REQ  = DEFAULT_N_REQ,
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  output logic [N_REQ-1:0]          req_ready,
  output logic                      out_valid,
  output logic [DATA_W-1:0]         out_data,
  output logic [$clog2(N_REQ)-1:0]  out_src,
  input  logic                      out_ready
);

  localparam int PTR_W  = $clog2(N_REQ);
  localparam int LEVELS = PTR_W;

  slot_state_t       state_q, state_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [PTR_W-1:0]  src_q, src_d;

  logic [PTR_W-1:0]  winner;
  logic              any_req;
  logic              can_load;
  logic              accept;
  logic [DATA_W-1:0] sel_data;

  rr_pick #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_pick (
    .req_i     (req_valid),
    .ptr_i     (ptr_q),
    .winner_o  (winner),
    .any_req_o (any_req)
  );

  // Level LEVELS holds the (zero-padded) leaves; level 0 node 0 is the root.
  for (genvar l = 0; l <= LEVELS; l++) begin : g_lvl
    logic [DATA_W-1:0] v [1<<l];
    for (genvar n = 0; n < (1 << l); n++) begin : g_node
      if (l == LEVELS) begin : g_leaf
        if (n < N_REQ) begin : g_in
          assign v[n] = req_data[n*DATA_W +: DATA_W];
        end else begin : g_pad
          assign v[n] = '0;
        end
      end else begin : g_mux
        assign v[n] = winner[LEVELS-1-l] ? g_lvl[l+1].v[2*n+1] : g_lvl[l+1].v[2*n];
      end
    end
  end

  assign sel_data = g_lvl[0].v[0];

  // No grant while reset is held: the slot cannot capture, so a handshake would lose data.
  assign can_load = (state_q == EMPTY) | out_ready;
  assign accept   = can_load & any_req & ~rst;

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[winner] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    data_d  = data_q;
    src_d   = src_q;
    if (accept) begin
      state_d = FULL;
      data_d  = sel_data;
      src_d   = winner;
      ptr_d   = (winner == PTR_W'(N_REQ-1)) ? '0 : winner + PTR_W'(1);
    end else if (out_ready) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      ptr_q   <= '0;
      data_q  <= '0;
      src_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      data_q  <= data_d;
      src_q   <= src_d;
    end
  end

  assign out_valid = (state_q == FULL);
  assign out_data  = data_q;
  assign out_src   = src_q;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed and randomized checks of rr_mux_arbiter against a behavioural model.
module tb_rr_mux_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int PW = $clog2(N);

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            out_valid;
  logic [DW-1:0]   out_data;
  logic [PW-1:0]   out_src;
  logic            out_ready;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  int          m_ptr;
  bit          m_valid;
  logic [7:0]  m_data;
  int          m_src;
  int          m_win;
  bit          m_acc;
  int          wait_cnt [N];
  int          max_wait;

  rr_mux_arbiter #(.N_REQ(N), .DATA_W(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_data  = 8'h00;
    m_src   = 0;
    m_ptr   = 0;
    for (int i = 0; i < N; i++) wait_cnt[i] = 0;
  endtask

  // Search the requesters in round-robin order starting at the pointer.
  task automatic model_pick();
    int idx;
    m_acc = 1'b0;
    m_win = 0;
    if (!rst && (!m_valid || out_ready)) begin
      for (int k = 0; k < N; k++) begin
        idx = (m_ptr + k) % N;
        if (req_valid[idx] && !m_acc) begin
          m_acc = 1'b1;
          m_win = idx;
        end
      end
    end
  endtask

  task automatic set_data(input int i, input logic [7:0] val);
    req_data[i*DW +: DW] = val;
  endtask

  // One clock: check ready before the edge, update model at the edge, check outputs after.
  task automatic cycle(input bit drop_on_accept);
    logic [N-1:0] exp_rdy;
    #2;
    model_pick();
    exp_rdy = '0;
    if (m_acc) exp_rdy[m_win] = 1'b1;
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    @(posedge clk);
    if (m_acc) begin
      for (int i = 0; i < N; i++) begin
        if (i != m_win && req_valid[i]) begin
          wait_cnt[i]++;
          if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
        end
      end
      wait_cnt[m_win] = 0;
      m_valid = 1'b1;
      m_data  = req_data[m_win*DW +: DW];
      m_src   = m_win;
      m_ptr   = (m_win + 1) % N;
    end else if (out_ready) begin
      m_valid = 1'b0;
    end
    #1;
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("out_data", 32'(out_data), 32'(m_data));
    chk("out_src", 32'(out_src), 32'(m_src));
    if (drop_on_accept && m_acc) req_valid[m_win] = 1'b0;
  endtask

  initial begin
    int lowest;
    max_wait  = 0;
    rst       = 1'b1;
    out_ready = 1'b1;
    req_data  = '0;
    for (int i = 0; i < N; i++) set_data(i, 8'(8'h10 + i));
    req_valid = N'($urandom_range(1, (1 << N) - 1));
    model_reset();

    // Reset held with random requests: no grant, empty slot
    for (int r = 0; r < 3; r++) begin
      @(posedge clk);
      #1;
      chk("rst_ready", 32'(req_ready), 32'h0);
      chk("rst_valid", 32'(out_valid), 32'h0);
      chk("rst_src", 32'(out_src), 32'h0);
      req_valid = N'($urandom_range(1, (1 << N) - 1));
    end
    rst = 1'b0;
    lowest = 0;
    for (int i = N - 1; i >= 0; i--) if (req_valid[i]) lowest = i;
    cycle(1'b0);
    chk("t1_first", 32'(out_src), 32'(lowest));
    req_valid = '0;
    cycle(1'b0);

    // Single requester 2
    set_data(2, 8'hA5);
    req_valid = 4'b0100;
    cycle(1'b1);
    chk("t2_data", 32'(out_data), 32'hA5);
    chk("t2_src", 32'(out_src), 32'd2);
    cycle(1'b1);
    chk("t2_drain", 32'(out_valid), 32'h0);

    // Fresh pointer, then all four requesters continuously
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < N; i++) set_data(i, 8'(i * 8'h11));
    req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      cycle(1'b0);
      chk("t3_src", 32'(out_src), 32'(k % N));
      chk("t3_data", 32'(out_data), 32'((k % N) * 8'h11));
    end

    // Backpressure with the slot full
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cycle(1'b0);
      chk("t4_stable", 32'(out_data), 32'h33);
    end
    out_ready = 1'b1;
    cycle(1'b0);
    chk("t4_next", 32'(out_src), 32'd0);

    // Pointer wrap: winner 3, then 0 and 3 pending
    req_valid = 4'b1000;
    cycle(1'b1);
    chk("t5_w3", 32'(out_src), 32'd3);
    req_valid = 4'b1001;
    cycle(1'b1);
    chk("t5_w0", 32'(out_src), 32'd0);
    cycle(1'b1);
    chk("t5_w3b", 32'(out_src), 32'd3);
    cycle(1'b1);

    // Asynchronous reset between edges while full
    set_data(1, 8'h5C);
    req_valid = 4'b0010;
    out_ready = 1'b0;
    cycle(1'b1);
    chk("t6_full", 32'(out_valid), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_async_valid", 32'(out_valid), 32'h0);
    chk("t6_async_data", 32'(out_data), 32'h0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    cycle(1'b1);
    chk("t6_no_replay", 32'(out_valid), 32'h0);
    cycle(1'b1);

    // Randomized producers and consumer
    max_wait = 0;
    for (int i = 0; i < N; i++) wait_cnt[i] = 0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && ($urandom_range(0, 2) == 0)) begin
          req_valid[i] = 1'b1;
          set_data(i, 8'($urandom));
        end
      end
      out_ready = ($urandom_range(0, 3) != 0);
      cycle(1'b1);
    end
    chk("fairness", 32'(max_wait < N), 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
